// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit: shift-register scoreboard of in-flight
// instructions (EX..WB), youngest-first operand forwarding per read port,
// load-use stall generation, branch-flush squash and a stall-cycle counter.
module hazard_fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 3,
  parameter int NRD    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_W-1:0]      issue_rd,
  input  logic                  issue_we,
  input  logic                  issue_load,
  input  logic [NRD*REG_W-1:0]  src_addr,
  input  logic [NRD-1:0]        src_en,
  input  logic [NRD*DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0]     exe_result,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  flush,
  output logic [NRD*DATA_W-1:0] fwd_data,
  output logic [NRD-1:0]        fwd_hit,
  output logic                  stall,
  output logic [15:0]           stall_cnt
);

  // Scoreboard entries: index 0 = EX, 1 = MEM, DEPTH-1 = WB.
  logic [DEPTH-1:0]  entValid;
  logic [DEPTH-1:0]  entWe;
  logic [DEPTH-1:0]  entLoad;
  logic [DEPTH-1:0]  entReady;
  logic [REG_W-1:0]  entRd   [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];

  logic [DEPTH-1:0]  match [NRD];
  logic [NRD-1:0]    loadHit;
  logic              issueTake;

  // Entry 0 never holds captured data and the WB entry's ready/load flags
  // have no consumer once it retires.
  logic unusedBits;
  assign unusedBits = ^{entReady[0], entReady[DEPTH-1], entLoad[DEPTH-1]};

  // Per-port match vector against every in-flight entry; register 0 never matches.
  always_comb begin
    match   = '{default: '0};
    loadHit = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        match[p][i] = entValid[i] && entWe[i] &&
                      (entRd[i] == src_addr[p*REG_W +: REG_W]) &&
                      (src_addr[p*REG_W +: REG_W] != '0) && src_en[p];
      end
      loadHit[p] = match[p][0] && entLoad[0];
    end
  end

  // Load-use stall; a flush or reset suppresses it.
  always_comb begin
    stall     = !rst && issue_valid && !flush && (|loadHit);
    issueTake = issue_valid && !stall && !flush;
  end

  // Operand select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_data = rf_data;
    fwd_hit  = '0;
    if (!rst) begin
      for (int p = 0; p < NRD; p++) begin
        for (int i = DEPTH-1; i >= 0; i--) begin
          if (match[p][i]) begin
            fwd_hit[p] = 1'b1;
            if (i == 0) begin
              // For an EX-stage load this value is don't-care: stall is raised.
              fwd_data[p*DATA_W +: DATA_W] = exe_result;
            end else if (i == 1 && !entReady[1]) begin
              fwd_data[p*DATA_W +: DATA_W] = mem_result;
            end else begin
              fwd_data[p*DATA_W +: DATA_W] = entData[i];
            end
          end
        end
      end
    end
  end

  // Scoreboard shift: insert issue (or bubble), capture results as entries advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      entValid <= '0;
      entWe    <= '0;
      entLoad  <= '0;
      entReady <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entRd[i]   <= '0;
        entData[i] <= '0;
      end
    end else begin
      entValid[0] <= issueTake;
      entRd[0]    <= issue_rd;
      entWe[0]    <= issue_we;
      entLoad[0]  <= issue_load;
      entReady[0] <= 1'b0;
      entData[0]  <= '0;

      entValid[1] <= entValid[0];
      entRd[1]    <= entRd[0];
      entWe[1]    <= entWe[0];
      entLoad[1]  <= entLoad[0];
      entReady[1] <= !entLoad[0];
      entData[1]  <= entLoad[0] ? entData[0] : exe_result;

      for (int i = 1; i < DEPTH-1; i++) begin
        entValid[i+1] <= entValid[i];
        entRd[i+1]    <= entRd[i];
        entWe[i+1]    <= entWe[i];
        entLoad[i+1]  <= entLoad[i];
        if (i == 1 && !entReady[1]) begin
          entReady[i+1] <= 1'b1;
          entData[i+1]  <= mem_result;
        end else begin
          entReady[i+1] <= entReady[i];
          entData[i+1]  <= entData[i];
        end
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding unit for the pipelined CPU core, replacing the fixed two-source write-back switch. It tracks every in-flight instruction from EX through WB in a shift-register scoreboard of depth `DEPTH`. For each of `NRD` decode-stage source operands it supplies the youngest in-flight value. It stalls decode on load-use hazards, squashes the decode slot on a taken branch, and counts stall cycles for performance measurement.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_W`, 5, register address width
- `DEPTH`, 3, in-flight stages tracked: entry 0 = EX, 1 = MEM, `DEPTH-1` = WB; minimum 2
- `NRD`, 3, source-operand read ports (Rs, Rt, Rsi)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `issue_valid`  in  1  decode holds a valid instruction
- `issue_rd`  in  REG_W  destination of decode instruction
- `issue_we`  in  1  decode instruction writes `issue_rd`
- `issue_load`  in  1  decode instruction is a memory load
- `src_addr`  in  NRD*REG_W  source addresses; port p at bits [p*REG_W +: REG_W]
- `src_en`  in  NRD  port p is read by the decode instruction
- `rf_data`  in  NRD*DATA_W  register-file read data per port
- `exe_result`  in  DATA_W  ALU result of the entry-0 instruction, same cycle
- `mem_result`  in  DATA_W  load data of the entry-1 instruction, same cycle
- `flush`  in  1  taken branch resolved this cycle; squash the decode slot
- `fwd_data`  out  NRD*DATA_W  operand value per port
- `fwd_hit`  out  NRD  port p took a forwarded value
- `stall`  out  1  hold decode and fetch this cycle
- `stall_cnt`  out  16  saturating count of stalled cycles

## Operation
- Each entry holds `valid`, `rd`, `we`, `load`, `ready`, `data[DATA_W]`.
- Shift every cycle: entry[i+1] <= entry[i] for i = 0..DEPTH-2. Entry DEPTH-1 retires, and its write is then in the register file.
- Entry 0 is loaded with {issue_valid, issue_rd, issue_we, issue_load} when `issue_valid && !stall && !flush`. Otherwise entry 0 is loaded as a bubble (valid = 0).
- Capture into entry 1:
  - non-load from entry 0: data = `exe_result`, ready = 1
  - load from entry 0: ready = 0
- Capture into entry 2 of a not-ready entry 1 (load): data = `mem_result`, ready = 1. Ready entries keep their data as they shift.
- Per port p, `match_i` = valid_i && we_i && rd_i == src_addr_p && src_addr_p != 0 && src_en_p.
- Forwarding selects the lowest matching index i; the youngest instruction wins:
  - i = 0, non-load: `exe_result`
  - i = 0, load: hazard, and the value is don't-care
  - i = 1, not ready: `mem_result`
  - otherwise: data_i
  - no match: `rf_data` port p, with `fwd_hit[p]` = 0
- Register 0 is never forwarded.
- `stall` = issue_valid && !flush && (any port has an entry-0 load match).
- `flush` overrides `stall`: stall = 0, and the decode instruction is dropped (entry 0 gets a bubble).
- `stall_cnt` increments on each cycle with stall = 1 and saturates at 16'hFFFF.

## Timing
- `fwd_data`, `fwd_hit` and `stall` are combinational from scoreboard state and the current inputs. There are no registered outputs except `stall_cnt`.
- Load-use costs exactly 1 stall cycle. In the next cycle the load sits in entry 1 and `mem_result` is forwarded.
- Back-to-back writes to the same `rd`: the younger entry shadows the older one.
- WB-stage (entry DEPTH-1) match: the value is forwarded. The register file need not be write-first.
- On `rst` at a clock edge:
  - all entries become valid = 0, ready = 0, data = 0
  - `stall_cnt` = 0
- While `rst` is held:
  - `fwd_data` = `rf_data`
  - `fwd_hit` = 0
  - `stall` = 0
- Reset in mid-stall discards the stalled instruction's hazard. Upstream reissues it.
- Simultaneous `flush` and load-use: flush wins, with no stall and no count.
- With `issue_valid` = 0, `stall` is 0 regardless of `src_en`.

## Test plan
- Reset, then issue with src_addr[0] = 4 and rf_data[0] = 32'h11 and no producers: fwd_data[0] = 32'h11, fwd_hit = 0, stall = 0, stall_cnt = 0.
- Issue `add r4` (exe_result = 32'hA5), then the next instruction reads r4 on port 1: fwd_data[1] = 32'hA5 with 0 stall. Two cycles later a reader gets 32'hA5 from entry 2 (WB).
- Issue `load r7`, then a reader of r7 on port 0:
  - cycle +1: stall = 1, stall_cnt = 1
  - cycle +2 with mem_result = 32'hDEAD: stall = 0 and fwd_data[0] = 32'hDEAD
- Issue `add r3` = 1 then `add r3` = 2, then a reader of r3: value 2, taken from entry 0 rather than 1. Also check that a reader of r0 with an r0 producer in flight gets rf_data.
- Load-use hazard with flush = 1 in the same cycle: stall = 0, stall_cnt unchanged, and entry 0 is a bubble (a following reader of that rd gets rf_data).
- Force 65,540 consecutive load-use stalls: stall_cnt holds at 16'hFFFF. Assert rst mid-stall: the next cycle has stall = 0 and stall_cnt = 0.
